// File: rtl/vfd_pkg.sv
// Shared constants for the VFD phase sequencer: step count, phase offsets, quarter-wave sine table, FSM states.
// Latency: none (constants and types only).
// Backpressure: none.
package vfd_pkg;

   localparam logic [5:0] STEPS    = 6'd48;   // electrical steps per revolution
   localparam logic [5:0] LAST_IDX = 6'd47;   // highest phase index
   localparam logic [5:0] HALF     = 6'd24;   // start of the negative half-wave
   localparam logic [5:0] QTR      = 6'd12;   // quarter-wave peak index
   localparam logic [5:0] PH_OFS   = 6'd16;   // 120 degrees in steps
   localparam logic [7:0] MID      = 8'd128;  // zero-volt duty word

   // round(127*sin(2*pi*k/48)) for k = 0..12; the rest of the wave is folded onto this
   localparam logic [6:0] SINE_QW [0:12] = '{
      7'd0,   7'd17,  7'd33,  7'd49,  7'd64,  7'd77,  7'd90,
      7'd101, 7'd110, 7'd117, 7'd123, 7'd126, 7'd127
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

endpackage

// File: rtl/step_edge_sync.sv
// Synchronises the asynchronous step clock into clk_in and emits a one-cycle tick on its rising edge.
// Latency: tick is high SYNC_STAGES cycles after step_clk is first captured.
// Backpressure: none; a step_clk high time under two clk_in periods is not supported.
module step_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic reset,
   input  logic i_step_clk,
   output logic o_tick
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Synchroniser chain plus one delayed copy of its output for edge detection
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_step_clk};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_tick = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/vf_phase_sequencer.sv
// Advances a 48-step phase index on each step-clock tick and produces U/V/W sine duty words scaled by amp.
// Latency: tick at T -> phase_idx at T+1 -> duty words and duty_valid at T+2.
// Backpressure: none; ticks are consumed as they arrive. Optional build macro: VFSEQ_SOFTSTART_EN.
module vf_phase_sequencer
   import vfd_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DUTY_W      = 8
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              i_step_clk,
   input  logic              i_enable,
   input  logic              i_dir,
   input  logic [7:0]        i_amp,
   output logic [5:0]        o_phase_idx,
   output logic [DUTY_W-1:0] o_duty_u,
   output logic [DUTY_W-1:0] o_duty_v,
   output logic [DUTY_W-1:0] o_duty_w,
   output logic              o_duty_valid,
   output logic              o_cycle_wrap,
   output logic              o_running
);

   localparam logic [DUTY_W-1:0] DUTY_MID = {1'b1, {(DUTY_W-1){1'b0}}};

   logic              w_tick;
   state_t            r_state;
   logic [5:0]        r_idx;
   logic [7:0]        r_amp_eff;
   logic              r_upd;
   logic              r_wrap;
   logic              r_running;
   logic [5:0]        w_idx_next;
   logic              w_wrap_next;
   logic [7:0]        w_amp_run;
   logic [5:0]        w_k_v;
   logic [5:0]        w_k_w;
   logic [DUTY_W-1:0] r_duty_u;
   logic [DUTY_W-1:0] r_duty_v;
   logic [DUTY_W-1:0] r_duty_w;
   logic              r_duty_valid;

   step_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in     (clk_in),
      .reset      (reset),
      .i_step_clk (i_step_clk),
      .o_tick     (w_tick)
   );

   // Signed sine sample at step k, scaled by amplitude and offset around the zero-volt midpoint
   function automatic logic [DUTY_W-1:0] duty_of(input logic [5:0] k, input logic [7:0] a);
      logic        neg;
      logic [5:0]  r;
      logic [15:0] prod;
      logic [7:0]  mag;
      neg  = (k >= HALF);
      r    = neg ? (k - HALF) : k;
      if (r > QTR) r = HALF - r;
      prod = 16'(a) * 16'(SINE_QW[4'(r)]);
      mag  = 8'(prod >> 8);
      return neg ? (DUTY_MID - DUTY_W'(mag)) : (DUTY_MID + DUTY_W'(mag));
   endfunction

   // Next phase index in the sampled direction, flagging the 47<->0 wrap
   always_comb begin
      w_idx_next  = r_idx;
      w_wrap_next = 1'b0;
      if (i_dir) begin
         if (r_idx == 6'd0) begin
            w_idx_next  = LAST_IDX;
            w_wrap_next = 1'b1;
         end else begin
            w_idx_next = r_idx - 6'd1;
         end
      end else begin
         if (r_idx == LAST_IDX) begin
            w_idx_next  = 6'd0;
            w_wrap_next = 1'b1;
         end else begin
            w_idx_next = r_idx + 6'd1;
         end
      end
   end

   // Amplitude applied on a RUN tick: slewed one LSB at a time, or taken directly
   always_comb begin
      w_amp_run = i_amp;
`ifdef VFSEQ_SOFTSTART_EN
      if (r_amp_eff < i_amp)
         w_amp_run = r_amp_eff + 8'd1;
      else if (r_amp_eff > i_amp)
         w_amp_run = r_amp_eff - 8'd1;
      else
         w_amp_run = r_amp_eff;
`endif
   end

   // Run/stop sequencing of phase index and effective amplitude
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_idx     <= 6'd0;
         r_amp_eff <= 8'd0;
         r_upd     <= 1'b0;
         r_wrap    <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_upd  <= 1'b0;
         r_wrap <= 1'b0;
         case (r_state)
            IDLE: begin
               r_idx     <= 6'd0;
               r_amp_eff <= 8'd0;
               if (i_enable) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
            end
            RUN: begin
               // A tick coinciding with enable falling is dropped
               if (!i_enable) begin
                  r_state <= STOP;
               end else if (w_tick) begin
                  r_idx     <= w_idx_next;
                  r_wrap    <= w_wrap_next;
                  r_amp_eff <= w_amp_run;
                  r_upd     <= 1'b1;
               end
            end
            STOP: begin
               if (i_enable) begin
                  r_state <= RUN;
`ifdef VFSEQ_SOFTSTART_EN
               end else if (r_amp_eff == 8'd0) begin
                  r_state   <= IDLE;
                  r_running <= 1'b0;
                  r_idx     <= 6'd0;
                  r_upd     <= 1'b1;
               end else if (w_tick) begin
                  r_idx     <= w_idx_next;
                  r_wrap    <= w_wrap_next;
                  r_amp_eff <= r_amp_eff - 8'd1;
                  r_upd     <= 1'b1;
               end
`else
               end else begin
                  r_state   <= IDLE;
                  r_running <= 1'b0;
                  r_idx     <= 6'd0;
                  r_amp_eff <= 8'd0;
                  r_upd     <= 1'b1;
               end
`endif
            end
            default: begin
               r_state   <= IDLE;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   // V lags U by 16 steps, W leads U by 16 steps (mod 48)
   assign w_k_v = (r_idx >= PH_OFS) ? (r_idx - PH_OFS) : (r_idx + (STEPS - PH_OFS));
   assign w_k_w = (r_idx < (STEPS - PH_OFS)) ? (r_idx + PH_OFS) : (r_idx - (STEPS - PH_OFS));

   // Duty words follow the index/amplitude stage by one cycle
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_duty_u     <= DUTY_MID;
         r_duty_v     <= DUTY_MID;
         r_duty_w     <= DUTY_MID;
         r_duty_valid <= 1'b0;
      end else begin
         r_duty_valid <= r_upd;
         if (r_upd) begin
            r_duty_u <= duty_of(r_idx, r_amp_eff);
            r_duty_v <= duty_of(w_k_v, r_amp_eff);
            r_duty_w <= duty_of(w_k_w, r_amp_eff);
         end
      end
   end

   assign o_phase_idx  = r_idx;
   assign o_duty_u     = r_duty_u;
   assign o_duty_v     = r_duty_v;
   assign o_duty_w     = r_duty_w;
   assign o_duty_valid = r_duty_valid;
   assign o_cycle_wrap = r_wrap;
   assign o_running    = r_running;

endmodule

// File: tb/tb_vf_phase_sequencer.sv
// Self-checking bench for vf_phase_sequencer: vector table plus hand sequences, scoreboard on duty_valid.
// Latency: expects duty_valid four clk_in edges after step_clk rises (2 sync + edge + 2 pipeline).
// Backpressure: none.
module tb_vf_phase_sequencer;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       step;
   logic       en;
   logic       dir;
   logic [7:0] amp;
   logic [5:0] o_phase_idx;
   logic [7:0] o_duty_u;
   logic [7:0] o_duty_v;
   logic [7:0] o_duty_w;
   logic       o_duty_valid;
   logic       o_cycle_wrap;
   logic       o_running;

   always #5 clk_in = ~clk_in;

   vf_phase_sequencer #(
      .SYNC_STAGES (2),
      .DUTY_W      (8)
   ) dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .i_step_clk   (step),
      .i_enable     (en),
      .i_dir        (dir),
      .i_amp        (amp),
      .o_phase_idx  (o_phase_idx),
      .o_duty_u     (o_duty_u),
      .o_duty_v     (o_duty_v),
      .o_duty_w     (o_duty_w),
      .o_duty_valid (o_duty_valid),
      .o_cycle_wrap (o_cycle_wrap),
      .o_running    (o_running)
   );

   typedef struct {
      int idx;
      int u;
      int v;
      int w;
   } exp_t;

   typedef struct {
      logic       d;
      logic [7:0] a;
      int         n;
      int         idx;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks    = 0;
   int   failures  = 0;
   int   valid_cnt = 0;
   int   wrap_cnt  = 0;
   int   m_idx     = 0;
   int   m_amp     = 0;
   int   mode      = 0;   // 0 idle, 1 running, 2 soft stopping
   int   qw [13]   = '{0, 17, 33, 49, 64, 77, 90, 101, 110, 117, 123, 126, 127};

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sine_s(input int k);
      int r;
      int v;
      r = k % 24;
      v = (r > 12) ? qw[24 - r] : qw[r];
      return (k >= 24) ? -v : v;
   endfunction

   function automatic int duty_exp(input int a, input int k);
      int s;
      int m;
      s = sine_s(k);
      m = (a * ((s < 0) ? -s : s)) / 256;
      return (s < 0) ? 128 - m : 128 + m;
   endfunction

   function automatic void push_exp();
      exp_t e;
      e.idx = m_idx;
      e.u   = duty_exp(m_amp, m_idx);
      e.v   = duty_exp(m_amp, (m_idx + 32) % 48);
      e.w   = duty_exp(m_amp, (m_idx + 16) % 48);
      sb.push_back(e);
   endfunction

   function automatic void model_step();
      if (mode == 1) begin
         m_idx = dir ? (m_idx + 47) % 48 : (m_idx + 1) % 48;
`ifdef VFSEQ_SOFTSTART_EN
         if (m_amp < int'(amp)) m_amp++;
         else if (m_amp > int'(amp)) m_amp--;
`else
         m_amp = int'(amp);
`endif
         push_exp();
      end else if (mode == 2) begin
         m_idx = dir ? (m_idx + 47) % 48 : (m_idx + 1) % 48;
         m_amp--;
         push_exp();
         if (m_amp == 0) begin
            m_idx = 0;
            push_exp();
            mode = 0;
         end
      end
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic do_tick();
      model_step();
      step = 1'b1;
      wait_cyc(3);
      step = 1'b0;
      wait_cyc(3);
   endtask

   task automatic raise_enable();
      en   = 1'b1;
      mode = 1;
      wait_cyc(2);
   endtask

   task automatic drop_enable();
      en = 1'b0;
`ifdef VFSEQ_SOFTSTART_EN
      if (m_amp == 0) begin
         m_idx = 0;
         push_exp();
         mode = 0;
      end else begin
         mode = 2;
      end
`else
      m_amp = 0;
      m_idx = 0;
      push_exp();
      mode = 0;
`endif
   endtask

   // Scoreboard and wrap monitor, sampled on the inactive edge
   always @(negedge clk_in) begin
      if (o_duty_valid) begin
         valid_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("sb_idx", int'(o_phase_idx), mon_e.idx);
            check("sb_duty_u", int'(o_duty_u), mon_e.u);
            check("sb_duty_v", int'(o_duty_v), mon_e.v);
            check("sb_duty_w", int'(o_duty_w), mon_e.w);
         end
      end
      if (o_cycle_wrap) begin
         wrap_cnt++;
         check("wrap_pos", int'(o_phase_idx), dir ? 47 : 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      vec_t vecs [5];
      int   lat;
      int   w0;
      int   v0;
      int   idx0;
      int   n;

      vecs[0] = '{1'b0, 8'd255, 3, 4};
      vecs[1] = '{1'b0, 8'd255, 8, 12};
      vecs[2] = '{1'b1, 8'd200, 5, 7};
      vecs[3] = '{1'b0, 8'd90, 17, 24};
      vecs[4] = '{1'b0, 8'd255, 23, 47};

      reset = 1'b1; step = 1'b0; en = 1'b0; dir = 1'b0; amp = 8'd0;
      wait_cyc(3);
      check("rst_idx", int'(o_phase_idx), 0);
      check("rst_du", int'(o_duty_u), 128);
      check("rst_dv", int'(o_duty_v), 128);
      check("rst_dw", int'(o_duty_w), 128);
      check("rst_valid", int'(o_duty_valid), 0);
      check("rst_running", int'(o_running), 0);
      reset = 1'b0;
      wait_cyc(2);

      // Ticks while idle do nothing
      do_tick();
      check("idle_idx", int'(o_phase_idx), 0);
      check("idle_running", int'(o_running), 0);

      amp = 8'd255;
      raise_enable();
      check("run_running", int'(o_running), 1);

      // First tick: measure step_clk-to-valid latency
      model_step();
      step = 1'b1;
      lat  = 0;
      for (int i = 1; i <= 8; i++) begin
         wait_cyc(1);
         if (i == 3) step = 1'b0;
         if (o_duty_valid && lat == 0) lat = i;
      end
      check("valid_latency", lat, 4);

      for (int i = 0; i < 5; i++) begin
         dir = vecs[i].d;
         amp = vecs[i].a;
         repeat (vecs[i].n) do_tick();
         check("vec_idx", int'(o_phase_idx), vecs[i].idx);
`ifndef VFSEQ_SOFTSTART_EN
         if (i == 0) begin
            check("idx4_du", int'(o_duty_u), 191);
            check("idx4_dv", int'(o_duty_v), 2);
            check("idx4_dw", int'(o_duty_w), 191);
         end
         if (i == 1) begin
            check("idx12_du", int'(o_duty_u), 254);
            check("idx12_dv", int'(o_duty_v), 65);
            check("idx12_dw", int'(o_duty_w), 65);
         end
`endif
      end

      // Forward wrap 47 -> 0, then a full revolution
      w0 = wrap_cnt;
      do_tick();
      check("wrap_idx", int'(o_phase_idx), 0);
      check("wrap_once", wrap_cnt - w0, 1);
      w0 = wrap_cnt;
      repeat (48) do_tick();
      check("rev48_idx", int'(o_phase_idx), 0);
      check("rev48_wraps", wrap_cnt - w0, 1);

      // Reverse from 0
      dir = 1'b1;
      w0  = wrap_cnt;
      do_tick();
      check("rev_idx47", int'(o_phase_idx), 47);
      check("rev_wrap", wrap_cnt - w0, 1);
      do_tick();
      check("rev_idx46", int'(o_phase_idx), 46);
      do_tick();
      check("rev_idx45", int'(o_phase_idx), 45);

      // enable falls in the same cycle as a tick
      dir  = 1'b0;
      idx0 = int'(o_phase_idx);
      step = 1'b1;
      wait_cyc(2);
      drop_enable();
      wait_cyc(1);
      check("t6_idx_hold", int'(o_phase_idx), idx0);
      check("t6_running", int'(o_running), 1);
      step = 1'b0;
      wait_cyc(1);
`ifdef VFSEQ_SOFTSTART_EN
      check("t6_state", int'(o_running), 1);
`else
      check("t6_state", int'(o_running), 0);
`endif
      wait_cyc(3);
      n = 0;
      while (mode == 2 && n < 300) begin
         do_tick();
         n++;
      end
      wait_cyc(4);
      check("t6_idle_idx", int'(o_phase_idx), 0);
      check("t6_idle_running", int'(o_running), 0);
      check("t6_idle_du", int'(o_duty_u), 128);

      // Small amplitude run and stop
      amp = 8'd3;
      raise_enable();
      repeat (4) do_tick();
      check("t5_idx", int'(o_phase_idx), 4);
      v0 = valid_cnt;
      drop_enable();
      n = 0;
      while (mode == 2 && n < 10) begin
         do_tick();
         n++;
      end
      wait_cyc(4);
`ifdef VFSEQ_SOFTSTART_EN
      check("t5_stop_ticks", n, 3);
      check("t5_valids", valid_cnt - v0, 4);
`else
      check("t5_valids", valid_cnt - v0, 1);
`endif
      check("t5_running", int'(o_running), 0);
      check("t5_dv", int'(o_duty_v), 128);

      // Asynchronous reset in the middle of a run
      amp = 8'd255;
      raise_enable();
      repeat (4) do_tick();
      @(posedge clk_in);
      #3;
      reset = 1'b1;
      #1;
      check("arst_idx", int'(o_phase_idx), 0);
      check("arst_du", int'(o_duty_u), 128);
      check("arst_dv", int'(o_duty_v), 128);
      check("arst_dw", int'(o_duty_w), 128);
      check("arst_valid", int'(o_duty_valid), 0);
      check("arst_wrap", int'(o_cycle_wrap), 0);
      check("arst_running", int'(o_running), 0);
      sb.delete();
      mode  = 0;
      m_idx = 0;
      m_amp = 0;
      en    = 1'b0;
      wait_cyc(2);
      reset = 1'b0;
      v0    = valid_cnt;
      do_tick();
      wait_cyc(10);
      check("post_rst_valids", valid_cnt - v0, 0);
      check("post_rst_running", int'(o_running), 0);

      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
